// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between CPUS instruction and data caches.
// Data requests always win over instruction requests. Each class has its own
// round-robin pointer. A coherent write (cctrans & ccwrite) first spends
// SNOOP_CYCLES cycles in SNOOP, invalidating the other CPUs, before the RAM
// access.
//
// Build option: define MEM_ARBITER_SNOOP_EN to include the SNOOP state and the
// coherence outputs. Without it, D grants go straight to DACC and
// ccwait/ccinv/ccsnoopaddr are tied to 0.
//
// Handshake: a CPU raises iREN, dREN or dWEN and holds it, with stable address
// and data, while its wait output is high. The request completes in the single
// cycle where that CPU's wait output is low. In that cycle the load output
// carries the RAM data. If a CPU drops its request early, the access is
// abandoned and nothing is returned.
//
// Debug outputs dbg_state, dbg_gnt, dbg_dptr and dbg_iptr expose the FSM
// state, the grant index and both round-robin pointers.

module mem_arbiter #(
    parameter int  CPUS         = 2,
    parameter int  SNOOP_CYCLES = 1,
    localparam int PW           = (CPUS > 1) ? $clog2(CPUS) : 1
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS-1:0]        ccwrite,
    input  logic [CPUS-1:0]        cctrans,
    input  logic [CPUS-1:0][31:0]  iaddr,
    input  logic [CPUS-1:0][31:0]  daddr,
    input  logic [CPUS-1:0][31:0]  dstore,
    output logic [CPUS-1:0]        iwait,
    output logic [CPUS-1:0]        dwait,
    output logic [CPUS-1:0][31:0]  iload,
    output logic [CPUS-1:0][31:0]  dload,
    output logic [CPUS-1:0]        ccwait,
    output logic [CPUS-1:0]        ccinv,
    output logic [CPUS-1:0][31:0]  ccsnoopaddr,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [31:0]            ramaddr,
    output logic [31:0]            ramstore,
    input  logic [31:0]            ramload,
    input  logic [1:0]             ramstate,
    output logic [1:0]             dbg_state,
    output logic [PW-1:0]          dbg_gnt,
    output logic [PW-1:0]          dbg_dptr,
    output logic [PW-1:0]          dbg_iptr
);

    // Only the ACCESS encoding matters here. FREE, BUSY and ERROR all mean
    // "not this cycle".
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    // The encoding is fixed so that dbg_state reads the same in both builds.
`ifdef MEM_ARBITER_SNOOP_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        DACC  = 2'd2,
        IACC  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DACC  = 2'd2,
        IACC  = 2'd3
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [PW-1:0]   dptr_q, dptr_d;
    logic [PW-1:0]   iptr_q, iptr_d;
`ifdef MEM_ARBITER_SNOOP_EN
    logic [1:0]      snoop_cnt_q, snoop_cnt_d;
`else
    // Coherence inputs and the snoop length have no effect in this build.
    logic [CPUS-1:0] unused_cc;
    logic [2:0]      unused_snoop_cycles;
    assign unused_cc           = ccwrite ^ cctrans;
    assign unused_snoop_cycles = 3'(SNOOP_CYCLES);
`endif

    // Returns {found, index}: the first set bit of req, starting at ptr and
    // wrapping upward modulo CPUS. Scanning from the far end lets the
    // lowest offset win.
    function automatic logic [PW:0] pick(input logic [CPUS-1:0] req,
                                         input logic [PW-1:0]   ptr);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int i = CPUS - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % CPUS;
            if (req[idx]) begin
                res = {1'b1, PW'(idx)};
            end
        end
        return res;
    endfunction

    // Advances a pointer to (p + 1) mod CPUS. With CPUS == 1 it stays at 0.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (int'(p) >= CPUS - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    logic [PW:0] d_pick;
    logic [PW:0] i_pick;
    logic        d_req_g;
    logic        i_req_g;

    assign d_pick  = pick(dREN | dWEN, dptr_q);
    assign i_pick  = pick(iREN, iptr_q);
    assign d_req_g = dREN[gnt_q] | dWEN[gnt_q];
    assign i_req_g = iREN[gnt_q];

    assign dbg_state = state_q;
    assign dbg_gnt   = gnt_q;
    assign dbg_dptr  = dptr_q;
    assign dbg_iptr  = iptr_q;

    // State register, grant index and pointers. Reset aborts any transaction.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            dptr_q      <= '0;
            iptr_q      <= '0;
`ifdef MEM_ARBITER_SNOOP_EN
            snoop_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            dptr_q      <= dptr_d;
            iptr_q      <= iptr_d;
`ifdef MEM_ARBITER_SNOOP_EN
            snoop_cnt_q <= snoop_cnt_d;
`endif
        end
    end

    // Next-state logic: arbitration in IDLE, snoop countdown, and completion
    // or abandonment of the granted access.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        dptr_d      = dptr_q;
        iptr_d      = iptr_q;
`ifdef MEM_ARBITER_SNOOP_EN
        snoop_cnt_d = snoop_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (d_pick[PW]) begin
                    gnt_d   = d_pick[PW-1:0];
                    state_d = DACC;
`ifdef MEM_ARBITER_SNOOP_EN
                    if (cctrans[d_pick[PW-1:0]] && ccwrite[d_pick[PW-1:0]]) begin
                        state_d     = SNOOP;
                        snoop_cnt_d = '0;
                    end
`endif
                end else if (i_pick[PW]) begin
                    gnt_d   = i_pick[PW-1:0];
                    state_d = IACC;
                end
            end
`ifdef MEM_ARBITER_SNOOP_EN
            SNOOP: begin
                if (!d_req_g) begin
                    state_d = IDLE;
                end else if (snoop_cnt_q == 2'(SNOOP_CYCLES - 1)) begin
                    state_d = DACC;
                end else begin
                    snoop_cnt_d = snoop_cnt_q + 2'd1;
                end
            end
`endif
            DACC: begin
                if (!d_req_g) begin
                    state_d = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    state_d = IDLE;
                    dptr_d  = next_ptr(gnt_q);
                end
            end
            IACC: begin
                if (!i_req_g) begin
                    state_d = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    state_d = IDLE;
                    iptr_d  = next_ptr(gnt_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: every wait defaults high and every load and enable
    // defaults to 0. Only the granted CPU can see a low wait, and only in
    // an ACCESS cycle.
    always_comb begin
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state_q)
`ifdef MEM_ARBITER_SNOOP_EN
            SNOOP: begin
                for (int k = 0; k < CPUS; k++) begin
                    if (PW'(k) != gnt_q) begin
                        ccwait[k]      = 1'b1;
                        ccinv[k]       = 1'b1;
                        ccsnoopaddr[k] = daddr[gnt_q];
                    end
                end
            end
`endif
            DACC: begin
                if (d_req_g) begin
                    // Write wins when dREN and dWEN come together.
                    ramWEN   = dWEN[gnt_q];
                    ramREN   = !dWEN[gnt_q];
                    ramaddr  = daddr[gnt_q];
                    ramstore = dstore[gnt_q];
                    if (ramstate == RAM_ACCESS) begin
                        dwait[gnt_q] = 1'b0;
                        dload[gnt_q] = ramload;
                    end
                end
            end
            IACC: begin
                if (i_req_g) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr[gnt_q];
                    if (ramstate == RAM_ACCESS) begin
                        iwait[gnt_q] = 1'b0;
                        iload[gnt_q] = ramload;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter (CPUS=2, SNOOP_CYCLES=1). Snoop expectations follow
// MEM_ARBITER_SNOOP_EN.
module tb_mem_arbiter;

    localparam int          W   = 68;
    localparam logic [31:0] KEY = 32'hC3C3_0000;
`ifdef MEM_ARBITER_SNOOP_EN
    localparam bit SNOOP_ON = 1'b1;
`else
    localparam bit SNOOP_ON = 1'b0;
`endif

    typedef struct packed {
        logic        re;
        logic        we;
        logic        cc;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic [1:0]       iREN, dREN, dWEN, ccwrite, cctrans;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [1:0]       iwait, dwait, ccwait, ccinv;
    logic [1:0][31:0] iload, dload, ccsnoopaddr;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;
    logic [1:0]       dbg_state;
    logic [0:0]       dbg_gnt, dbg_dptr, dbg_iptr;

    mem_arbiter #(.CPUS(2), .SNOOP_CYCLES(1)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .ccwrite(ccwrite), .cctrans(cctrans),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .dbg_state(dbg_state), .dbg_gnt(dbg_gnt), .dbg_dptr(dbg_dptr), .dbg_iptr(dbg_iptr)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] rec(input bit is_d, input bit cpu, input bit we,
                                         input bit re, input logic [31:0] a,
                                         input logic [31:0] d);
        return {is_d, cpu, we, re, a, d};
    endfunction

    // ---------------- RAM responder ----------------
    int ram_lat = 1;
    bit ram_err = 1'b0;
    int ram_cnt = 0;

    // ACCESS arrives on the ram_lat-th consecutive enabled cycle.
    always @(negedge CLK) begin
        if (ramREN || ramWEN) begin
            if (ram_cnt + 1 >= ram_lat) begin
                ramstate = 2'd2;
                ramload  = ramaddr ^ KEY;
                ram_cnt  = 0;
            end else begin
                ramstate = ram_err ? 2'd3 : 2'd1;
                ramload  = 32'hDEAD_BEEF;
                ram_cnt  = ram_cnt + 1;
            end
        end else begin
            ramstate = 2'd0;
            ramload  = 32'hDEAD_BEEF;
            ram_cnt  = 0;
        end
    end

    // ---------------- stimulus tables / driver ----------------
    txn_t        dtx [2][8];
    logic [31:0] itx [2][8];
    int          dn[2], dh[2], in_n[2], ih[2];

    task automatic add_d(input int c, input bit re, input bit we, input bit cc,
                         input logic [31:0] a, input logic [31:0] d);
        dtx[c][dn[c]] = '{re: re, we: we, cc: cc, addr: a, data: d};
        dn[c]++;
    endtask

    task automatic add_i(input int c, input logic [31:0] a);
        itx[c][in_n[c]] = a;
        in_n[c]++;
    endtask

    // Presents each CPU's current head transaction, or idles it.
    task automatic apply();
        for (int c = 0; c < 2; c++) begin
            if (dh[c] < dn[c]) begin
                dREN[c]    = dtx[c][dh[c]].re;
                dWEN[c]    = dtx[c][dh[c]].we;
                ccwrite[c] = dtx[c][dh[c]].cc;
                cctrans[c] = dtx[c][dh[c]].cc;
                daddr[c]   = dtx[c][dh[c]].addr;
                dstore[c]  = dtx[c][dh[c]].data;
            end else begin
                dREN[c] = 1'b0; dWEN[c] = 1'b0; ccwrite[c] = 1'b0; cctrans[c] = 1'b0;
                daddr[c] = '0;  dstore[c] = '0;
            end
            if (ih[c] < in_n[c]) begin
                iREN[c]  = 1'b1;
                iaddr[c] = itx[c][ih[c]];
            end else begin
                iREN[c]  = 1'b0;
                iaddr[c] = '0;
            end
        end
    endtask

    function automatic bit all_done();
        return (dh[0] >= dn[0]) && (dh[1] >= dn[1]) && (ih[0] >= in_n[0]) && (ih[1] >= in_n[1]);
    endfunction

    task automatic clear_tables();
        for (int c = 0; c < 2; c++) begin
            dn[c] = 0; dh[c] = 0; in_n[c] = 0; ih[c] = 0;
        end
    endtask

    task automatic run(input int budget, input string name);
        int b;
        apply();
        b = 0;
        while (!all_done() && b < budget) begin
            @(posedge CLK); #1;
            apply();
            b++;
        end
        check(name, all_done(), 1'b1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"}, {iwait, dwait, ramREN, ramWEN, ccwait, ccinv},
              {2'b11, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00});
        check({name, "_loads"}, {iload, dload}, 128'h0);
        check({name, "_addr"}, {ccsnoopaddr, ramaddr, ramstore}, 128'h0);
        check({name, "_state"}, dbg_state, 2'd0);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        clear_tables();
        apply();
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        @(posedge CLK); #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    int           last_done_cyc = 0;
    int           snoop_seen    = 0;
    logic [31:0]  exp_snoop_addr = '0;

    always @(negedge CLK) begin
        logic [1:0]   lm_d, lm_i;
        logic         is_d, cpu;
        logic [31:0]  data;
        logic [W-1:0] act, exp;
        logic [95:0]  oth;
        #2;
        if (nRST) begin
            lm_d = ~dwait;
            lm_i = ~iwait;
            if (|{lm_d, lm_i}) begin
                check("one_wait_low", $countones({lm_d, lm_i}), 1);
                is_d = |lm_d;
                cpu  = is_d ? lm_d[1] : lm_i[1];
                data = ramWEN ? ramstore : (is_d ? dload[cpu] : iload[cpu]);
                act  = {is_d, cpu, ramWEN, ramREN, ramaddr, data};
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", act, '0);
                end else begin
                    exp = exp_q.pop_front();
                    check("completion", act, exp);
                end
                oth = is_d ? {iload, dload[~cpu]} : {iload[~cpu], dload};
                check("other_loads_zero", oth, 96'h0);
                if (is_d) dh[int'(cpu)]++;
                else      ih[int'(cpu)]++;
                last_done_cyc = cyc;
            end else begin
                check("loads_zero", {iload, dload}, 128'h0);
            end
            if (|{ccinv, ccwait}) begin
                snoop_seen++;
                check("snoop_ctl", {ccinv, ccwait, ramREN, ramWEN, dwait, iwait},
                      {2'b10, 2'b10, 1'b0, 1'b0, 2'b11, 2'b11});
                check("snoop_addr", {ccsnoopaddr[1], ccsnoopaddr[0]}, {exp_snoop_addr, 32'h0});
            end
        end
    end

    // ---------------- directed tests ----------------
    int start;

    initial begin
        nRST = 1'b0;
        ramstate = 2'd0;
        ramload = 32'hDEAD_BEEF;
        clear_tables();
        apply();
        #1;
        check_reset_outputs("reset");
        do_reset();

        // Single I read, ACCESS on the 3rd IACC cycle.
        ram_lat = 3;
        add_i(0, 32'h0000_0100);
        exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0100 ^ KEY));
        start = cyc;
        run(40, "t1_done");
        check("t1_latency", last_done_cyc - start, 3);
        check("t1_ptrs", {dbg_iptr, dbg_dptr, dbg_state}, {1'b1, 1'b0, 2'd0});

        // D on CPU0 and I on CPU1 together: D goes first.
        ram_lat = 2;
        add_d(0, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0);
        add_i(1, 32'h0000_0204);
        exp_q.push_back(rec(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0300 ^ KEY));
        exp_q.push_back(rec(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0204, 32'h0000_0204 ^ KEY));
        run(40, "t2_done");
        check("t2_ptrs", {dbg_dptr, dbg_iptr}, {1'b1, 1'b0});

        // Both CPUs hold writes: grants alternate CPU0, CPU1, CPU0.
        do_reset();
        ram_lat = 2;
        add_d(0, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h1111_0000);
        add_d(0, 1'b0, 1'b1, 1'b0, 32'h0000_0404, 32'h2222_0000);
        add_d(1, 1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h3333_0000);
        exp_q.push_back(rec(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h1111_0000));
        exp_q.push_back(rec(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h3333_0000));
        exp_q.push_back(rec(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0404, 32'h2222_0000));
        run(60, "t3_done");
        check("t3_dptr", dbg_dptr, 1'b1);

        // Read plus write from one CPU is a write; then I round-robin 0, 1.
        do_reset();
        ram_lat = 1;
        add_d(1, 1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0000_ABCD);
        add_i(0, 32'h0000_0700);
        add_i(1, 32'h0000_0704);
        exp_q.push_back(rec(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0000_ABCD));
        exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0700, 32'h0000_0700 ^ KEY));
        exp_q.push_back(rec(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0704, 32'h0000_0704 ^ KEY));
        run(60, "t4_done");
        check("t4_ptrs", {dbg_dptr, dbg_iptr}, {1'b0, 1'b0});

        // Five ERROR cycles, then ACCESS.
        do_reset();
        ram_lat = 6;
        ram_err = 1'b1;
        add_d(0, 1'b1, 1'b0, 1'b0, 32'h0000_0800, 32'h0);
        exp_q.push_back(rec(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0800, 32'h0000_0800 ^ KEY));
        start = cyc;
        run(40, "t5_done");
        check("t5_latency", last_done_cyc - start, 6);
        ram_err = 1'b0;

        // Coherent write from CPU0.
        do_reset();
        ram_lat = 2;
        snoop_seen = 0;
        exp_snoop_addr = 32'h0000_1040;
        add_d(0, 1'b0, 1'b1, 1'b1, 32'h0000_1040, 32'h5555_AAAA);
        exp_q.push_back(rec(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1040, 32'h5555_AAAA));
        start = cyc;
        run(40, "t6_done");
        check("t6_latency", last_done_cyc - start, SNOOP_ON ? 3 : 2);
        check("t6_snoop_cycles", snoop_seen, SNOOP_ON ? 1 : 0);

        // CPU1 drops its read mid-DACC: back to IDLE, dptr stays at 1.
        ram_lat = 100;
        add_d(1, 1'b1, 1'b0, 1'b0, 32'h0000_0900, 32'h0);
        apply();
        repeat (3) begin
            @(posedge CLK); #1;
        end
        check("t7_in_dacc", {dbg_state, dbg_gnt}, {2'd2, 1'b1});
        clear_tables();
        apply();
        #3;
        check("t7_drop_outputs", {ramREN, ramWEN, dwait, iwait}, {1'b0, 1'b0, 2'b11, 2'b11});
        @(posedge CLK); #1;
        check("t7_after_drop", {dbg_state, dbg_dptr, dbg_iptr}, {2'd0, 1'b1, 1'b0});

        // Reset in the middle of a DACC.
        add_d(0, 1'b1, 1'b0, 1'b0, 32'h0000_0A00, 32'h0);
        apply();
        repeat (2) begin
            @(posedge CLK); #1;
        end
        check("t8_in_dacc", {dbg_state, dbg_gnt}, {2'd2, 1'b0});
        nRST = 1'b0;
        #1;
        check_reset_outputs("t8_reset");
        check("t8_ptrs", {dbg_dptr, dbg_iptr, dbg_gnt}, 3'b000);
        clear_tables();
        apply();
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        check("t8_idle_after", dbg_state, 2'd0);

        repeat (3) @(posedge CLK);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Overall time limit.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule
